prog_loader: RTL and testbench

//  Writer side of the pipeline's instruction-memory interface: receives a byte stream, assembles
//  16-bit instructions, writes them into the instruction memory at PC addresses 0..N-1, then

---
 rtl/ldr_pkg.sv | 6 +
 rtl/instr_assembler.sv | 42 ++++
 rtl/prog_loader.sv | 107 ++++++++++
 tb/tb_prog_loader.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ldr_pkg.sv
// ldr_pkg: shared state encoding and widths for the program loader
package ldr_pkg;
    localparam int BYTE_W = 8;
    localparam int CNT_W  = 16;
    typedef enum logic [2:0] {IDLE, HDR, HI, LO, WR, RUN, DONE, ERR} state_e;
endpackage

// File: rtl/instr_assembler.sv
// instr_assembler: packs big-endian byte pairs into instruction words and tracks the write address
module instr_assembler
    import ldr_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               cnt_load,
    input  logic               hi_load,
    input  logic               lo_load,
    input  logic               advance,
    input  logic [BYTE_W-1:0]  byte_in,
    output logic [INSTR_W-1:0] wdata,
    output logic [ADDR_W-1:0]  addr,
    output logic               last
);
    logic [INSTR_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0]  addr_q, addr_d, last_q, last_d;
    always_comb begin
        wdata_d = clear ? '0 : hi_load ? {byte_in, wdata_q[BYTE_W-1:0]} :
                  lo_load ? {wdata_q[INSTR_W-1:BYTE_W], byte_in} : wdata_q;
        addr_d  = clear ? '0 : advance ? addr_q + ADDR_W'(1) : addr_q;
        last_d  = cnt_load ? ADDR_W'(byte_in - BYTE_W'(1)) : last_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            wdata_q <= '0;
            addr_q  <= '0;
            last_q  <= '0;
        end else begin
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
        end
    end
    assign wdata = wdata_q;
    assign addr  = addr_q;
    assign last  = addr_q == last_q;
endmodule

// File: rtl/prog_loader.sv
// prog_loader: loads a byte stream into instruction memory, then runs the pipeline and records the outcome
module prog_loader
    import ldr_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int INSTR_W     = 16,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_start,
    input  logic               byte_valid,
    input  logic [BYTE_W-1:0]  byte_data,
    output logic               byte_ready,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               en,
    input  logic               finish,
    input  logic               out,
    output logic               result,
    output logic [CNT_W-1:0]   run_cycles,
    output logic               done,
    output logic               error
);
    state_e             state_q, state_d;
    logic               done_q, done_d, error_q, error_d, result_q, result_d;
    logic [CNT_W-1:0]   run_q, run_d;
    logic               clear, cnt_load, hi_load, lo_load, advance, last, xfer;
    instr_assembler #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) u_asm (
        .clk(clk), .reset(reset), .clear(clear), .cnt_load(cnt_load), .hi_load(hi_load),
        .lo_load(lo_load), .advance(advance), .byte_in(byte_data), .wdata(imem_wdata),
        .addr(imem_addr), .last(last)
    );
    always_comb begin
        state_d    = state_q;
        done_d     = done_q;
        error_d    = error_q;
        result_d   = result_q;
        run_d      = run_q;
        clear      = 1'b0;
        cnt_load   = 1'b0;
        hi_load    = 1'b0;
        lo_load    = 1'b0;
        advance    = 1'b0;
        byte_ready = state_q inside {HDR, HI, LO};
        xfer       = byte_valid && byte_ready;
        case (state_q)
            IDLE, DONE, ERR: if (load_start) begin
                state_d  = HDR;
                clear    = 1'b1;
                done_d   = 1'b0;
                error_d  = 1'b0;
                result_d = 1'b0;
                run_d    = '0;
            end
            HDR: if (xfer) begin
                cnt_load = 1'b1;
                state_d  = HI;
            end
            HI: if (xfer) begin
                hi_load = 1'b1;
                state_d = LO;
            end
            LO: if (xfer) begin
                lo_load = 1'b1;
                state_d = WR;
            end
            WR: begin
                advance = !last;
                state_d = last ? RUN : HI;
            end
            RUN: begin
                run_d = &run_q ? run_q : run_q + CNT_W'(1);
                if (finish) begin
                    result_d = out;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end else if (run_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    error_d = 1'b1;
                    state_d = ERR;
                end
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            result_q <= 1'b0;
            run_q    <= '0;
        end else begin
            state_q  <= state_d;
            done_q   <= done_d;
            error_q  <= error_d;
            result_q <= result_d;
            run_q    <= run_d;
        end
    end
    assign imem_we    = state_q == WR;
    assign en         = state_q == RUN;
    assign result     = result_q;
    assign run_cycles = run_q;
    assign done       = done_q;
    assign error      = error_q;
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized self-checking bench comparing memory writes and run outcome to a stream-level model
module tb_prog_loader;
    localparam int TO = 16;
    logic        clk = 1'b0;
    logic        reset, load_start, byte_valid, finish, out;
    logic [7:0]  byte_data;
    logic        byte_ready, imem_we, en, result, done, error;
    logic [7:0]  imem_addr;
    logic [15:0] imem_wdata, run_cycles;
    int          n_chk = 0, n_fail = 0, cyc = 0, last_we_cyc = 0, first_en_cyc = 0;
    logic [23:0] obs[$];

    prog_loader #(.ADDR_W(8), .INSTR_W(16), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset), .load_start(load_start), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_ready(byte_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .en(en), .finish(finish), .out(out), .result(result),
        .run_cycles(run_cycles), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        if (imem_we) begin
            obs.push_back({imem_addr, imem_wdata});
            last_we_cyc = cyc;
        end
        if (en && first_en_cyc == 0) first_en_cyc = cyc;
    end

    task automatic send(input logic [7:0] b[$], input bit gaps);
        int i = 0;
        int guard = 0;
        while (i < b.size() && guard < 4000) begin
            @(negedge clk);
            byte_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            byte_data  = b[i];
            load_start = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            if (byte_valid && byte_ready) i++;
            guard++;
        end
        n_chk++;
        if (i != b.size()) begin
            n_fail++;
            $display("FAIL send: accepted %0d bytes, required %0d", i, b.size());
        end
    endtask

    task automatic do_load(input logic [7:0] b[$], input bit gaps);
        int g = 0;
        obs.delete();
        first_en_cyc = 0;
        last_we_cyc  = 0;
        @(negedge clk);
        load_start = 1'b1;
        byte_valid = 1'b0;
        @(negedge clk);
        load_start = 1'b0;
        #1;
        n_chk++;
        if (done !== 1'b0 || error !== 1'b0 || result !== 1'b0 || run_cycles !== 16'd0) begin
            n_fail++;
            $display("FAIL load_clear: done=%b error=%b result=%b run=%0d, required all 0",
                     done, error, result, run_cycles);
        end
        send(b, gaps);
        while (!en && g < 1000) begin
            @(negedge clk);
            byte_valid = 1'b0;
            load_start = 1'b0;
            #1;
            g++;
        end
        n_chk++;
        if (en !== 1'b1) begin
            n_fail++;
            $display("FAIL en_rise: en=%b after %0d cycles, required 1", en, g);
        end
    endtask

    task automatic check_writes(input logic [7:0] b[$]);
        int n = (b[0] == 8'd0) ? 256 : int'(b[0]);
        logic [23:0] exp;
        n_chk++;
        if (obs.size() != n) begin
            n_fail++;
            $display("FAIL write_count: got %0d writes, required %0d", obs.size(), n);
        end
        for (int k = 0; k < n && k < obs.size(); k++) begin
            exp = {8'(k), b[2*k+1], b[2*k+2]};
            n_chk++;
            if (obs[k] !== exp) begin
                n_fail++;
                $display("FAIL write_%0d: got %h, required %h", k, obs[k], exp);
            end
        end
        n_chk++;
        if (first_en_cyc != last_we_cyc + 1) begin
            n_fail++;
            $display("FAIL en_timing: en at cycle %0d, required %0d", first_en_cyc, last_we_cyc + 1);
        end
    endtask

    task automatic finish_run(input int k, input logic o);
        repeat (k - 1) @(negedge clk);
        finish = 1'b1;
        out    = o;
        @(negedge clk);
        finish = 1'b0;
        #1;
        n_chk++;
        if (done !== 1'b1 || error !== 1'b0 || en !== 1'b0 || result !== o || run_cycles !== 16'(k)) begin
            n_fail++;
            $display("FAIL finish_%0d: done=%b error=%b en=%b result=%b run=%0d, required 1 0 0 %b %0d",
                     k, done, error, en, result, run_cycles, o, k);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_chk++;
        if ({byte_ready, imem_we, en, result, done, error} !== 6'd0 || imem_addr !== 8'd0 ||
            imem_wdata !== 16'd0 || run_cycles !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_state: outputs nonzero, required all 0");
        end
        reset = 1'b0;
        obs.delete();
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        byte_valid = 1'b1;
        byte_data  = 8'h02;
        @(negedge clk);
        byte_data = 8'h12;
        @(negedge clk);
        reset     = 1'b1;
        byte_data = 8'h34;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_chk++;
        if ({byte_ready, imem_we, en, result, done, error} !== 6'd0 || imem_addr !== 8'd0 ||
            imem_wdata !== 16'd0 || run_cycles !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_midstream: outputs nonzero, required all 0");
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            n_chk++;
            if (byte_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle_%0d: byte_ready=%b, required 0", i, byte_ready);
            end
        end
        n_chk++;
        if (obs.size() != 0) begin
            n_fail++;
            $display("FAIL reset_nowrite: got %0d writes, required 0", obs.size());
        end
        byte_valid = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] b[$] = '{8'h02, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
        do_load(b, 1'b0);
        check_writes(b);
    endtask

    task automatic test_finish();
        finish_run(10, 1'b1);
        finish = 1'b1;
        out    = 1'b0;
        @(negedge clk);
        finish = 1'b0;
        #1;
        n_chk++;
        if (result !== 1'b1 || done !== 1'b1 || run_cycles !== 16'd10) begin
            n_fail++;
            $display("FAIL finish_ignored: result=%b done=%b run=%0d, required 1 1 10", result, done, run_cycles);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b[$] = '{8'h02, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
        do_load(b, 1'b1);
        check_writes(b);
        finish_run(int'($urandom_range(1, TO - 1)), 1'($urandom_range(0, 1)));
        for (int r = 0; r < 3; r++) begin
            int n = int'($urandom_range(1, 6));
            b.delete();
            b.push_back(8'(n));
            for (int i = 0; i < 2 * n; i++) b.push_back(8'($urandom));
            do_load(b, 1'b1);
            check_writes(b);
            finish_run(int'($urandom_range(1, TO - 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_max_load();
        logic [7:0] b[$];
        b.push_back(8'h00);
        for (int i = 0; i < 512; i++) b.push_back(8'($urandom));
        do_load(b, 1'b0);
        check_writes(b);
        finish_run(1, 1'($urandom_range(0, 1)));
    endtask

    task automatic test_timeout();
        logic [7:0] b[$] = '{8'h01, 8'h5A, 8'hC3};
        do_load(b, 1'b0);
        repeat (TO - 1) @(negedge clk);
        #1;
        n_chk++;
        if (en !== 1'b1 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_early: en=%b error=%b, required 1 0", en, error);
        end
        @(negedge clk);
        #1;
        n_chk++;
        if (error !== 1'b1 || en !== 1'b0 || done !== 1'b0 || run_cycles !== 16'(TO)) begin
            n_fail++;
            $display("FAIL timeout: error=%b en=%b done=%b run=%0d, required 1 0 0 %0d",
                     error, en, done, run_cycles, TO);
        end
        do_load(b, 1'b0);
        finish_run(TO, 1'b1);
    endtask

    initial begin
        reset      = 1'b1;
        load_start = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        finish     = 1'b0;
        out        = 1'b0;
        test_reset();
        test_basic();
        test_finish();
        test_back_to_back();
        test_max_load();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
